// File: rtl/prod_accum.sv
// rtl/prod_accum.sv - frame accumulator of unsigned product words with saturating sum
module prod_accum #(
    parameter int DW = 32,
    parameter int AW = 36
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [3:0]    cfg_len,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic          out_ovf
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [AW-1:0] ACC_MAX = {AW{1'b1}};

    logic [1:0]    state;
    logic [AW-1:0] acc;
    logic [4:0]    cnt;
    logic [4:0]    len;
    logic          ovf;

    logic          beat;
    logic [4:0]    len_new;
    logic [4:0]    cnt_nxt;
    logic [AW:0]   sum;

    // Handshake and next-value helpers; ready depends only on registered state
    always_comb begin
        in_ready = 1'b0;
        if (!rst && (state == IDLE || state == ACC))
            in_ready = 1'b1;
        beat    = in_valid && in_ready;
        len_new = (cfg_len == 4'd0) ? 5'd16 : {1'b0, cfg_len};
        cnt_nxt = cnt + 5'd1;
        sum     = {1'b0, acc} + {{(AW + 1 - DW){1'b0}}, in_data};
    end

    // Result outputs are only exposed while a frame is pending in DONE
    always_comb begin
        out_valid = (state == DONE);
        out_sum   = (state == DONE) ? acc : '0;
        out_ovf   = (state == DONE) ? ovf : 1'b0;
    end

    // Frame FSM, accumulator, beat counter and latched frame length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= 5'd0;
            len   <= 5'd16;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (beat) begin
                        len   <= len_new;
                        acc   <= in_data;
                        cnt   <= 5'd1;
                        ovf   <= 1'b0;
                        state <= (len_new == 5'd1) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (beat) begin
                        if (sum[AW]) begin
                            acc <= ACC_MAX;
                            ovf <= 1'b1;
                        end else begin
                            acc <= sum[AW-1:0];
                        end
                        cnt <= cnt_nxt;
                        if (cnt_nxt == len)
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prod_accum.sv
// tb/tb_prod_accum.sv - directed self-checking bench for prod_accum (AW=36 and AW=33 builds)
module tb_prod_accum;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic [3:0]  cfg_len;
    logic        out_ready;

    logic        in_ready, out_valid, out_ovf;
    logic [35:0] out_sum;
    logic        in_ready33, out_valid33, out_ovf33;
    logic [32:0] out_sum33;

    int n_cmp;
    int n_bad;

    prod_accum #(.DW(32), .AW(36)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cfg_len(cfg_len),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf)
    );

    prod_accum #(.DW(32), .AW(33)) u_dut33 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready33), .in_data(in_data),
        .cfg_len(cfg_len),
        .out_valid(out_valid33), .out_ready(out_ready),
        .out_sum(out_sum33), .out_ovf(out_ovf33)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d);
        @(negedge clk);
        chk("beat_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_data = 32'hDEAD_BEEF;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expects result visible at the next negedge, then retires the frame
    task automatic done(input string tag,
                        input logic [63:0] s36, input logic o36,
                        input logic [63:0] s33, input logic o33);
        @(negedge clk);
        chk({tag, "_valid"},   {63'd0, out_valid}, 64'd1);
        chk({tag, "_sum"},     {28'd0, out_sum}, s36);
        chk({tag, "_ovf"},     {63'd0, out_ovf}, {63'd0, o36});
        chk({tag, "_valid33"}, {63'd0, out_valid33}, 64'd1);
        chk({tag, "_sum33"},   {31'd0, out_sum33}, s33);
        chk({tag, "_ovf33"},   {63'd0, out_ovf33}, {63'd0, o33});
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_vlow"},  {63'd0, out_valid}, 64'd0);
        chk({tag, "_rdy"},   {63'd0, in_ready}, 64'd1);
        chk({tag, "_sum0"},  {28'd0, out_sum}, 64'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 32'd0;
        cfg_len = 4'd0;
        out_ready = 1'b0;

        idle(2);
        chk("rst_in_ready",  {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_sum",   {28'd0, out_sum}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {63'd0, in_ready}, 64'd1);

        // Five back-to-back words
        cfg_len = 4'd5;
        for (int i = 1; i <= 5; i++) begin
            beat(32'(i));
            if (i == 4) chk("mid_valid", {63'd0, out_valid}, 64'd0);
        end
        done("len5", 64'd15, 1'b0, 64'd15, 1'b0);

        // Single-word frame
        cfg_len = 4'd1;
        beat(32'hFFFF_FFFF);
        done("len1", 64'h0_FFFF_FFFF, 1'b0, 64'h0_FFFF_FFFF, 1'b0);

        // cfg_len 0 means 16 words; the 33-bit build saturates
        cfg_len = 4'd0;
        for (int i = 0; i < 16; i++) beat(32'hFFFF_FFFF);
        done("len16", 64'hF_FFFF_FFF0, 1'b0, 64'h1_FFFF_FFFF, 1'b1);

        // Three max words: only the 33-bit build overflows
        cfg_len = 4'd3;
        for (int i = 0; i < 3; i++) beat(32'hFFFF_FFFF);
        done("sat3", 64'h2_FFFF_FFFD, 1'b0, 64'h1_FFFF_FFFF, 1'b1);

        // No carry-over of overflow into the next frame
        cfg_len = 4'd2;
        beat(32'd1);
        beat(32'd1);
        done("fresh", 64'd2, 1'b0, 64'd2, 1'b0);

        // Back-pressure on the result
        beat(32'd7);
        beat(32'd9);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_sum",   {28'd0, out_sum}, 64'd16);
            chk("hold_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("hold_rel_valid", {63'd0, out_valid}, 64'd0);
        chk("hold_rel_ready", {63'd0, in_ready}, 64'd1);

        // Reset in the middle of a frame
        cfg_len = 4'd4;
        beat(32'd10);
        beat(32'd20);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_ready", {63'd0, in_ready}, 64'd0);
        chk("mrst_valid", {63'd0, out_valid}, 64'd0);
        chk("mrst_sum",   {28'd0, out_sum}, 64'd0);
        chk("mrst_ovf",   {63'd0, out_ovf}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) beat(32'd1);
        done("after_rst", 64'd4, 1'b0, 64'd4, 1'b0);

        // Gaps in in_valid and cfg_len change after the first word
        cfg_len = 4'd3;
        beat(32'd5);
        cfg_len = 4'd1;
        idle(2);
        chk("gap_valid0", {63'd0, out_valid}, 64'd0);
        beat(32'd6);
        idle(1);
        chk("gap_valid1", {63'd0, out_valid}, 64'd0);
        beat(32'd7);
        done("gaps", 64'd18, 1'b0, 64'd18, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
